// File: rtl/fb_scanout.sv
// fb_scanout: dumps the whole framebuffer over a valid/ready byte stream.
// On each frame_tick it sends a sync header byte, then every pixel read from
// the framebuffer's idle read port (port B, one-cycle read latency).
// Optional build macro FB_SCANOUT_CHECKSUM_EN appends a mod-256 checksum
// byte after the last pixel; that byte then carries m_last instead.
module fb_scanout #(
  parameter int                    ADDR_WIDTH  = 8,
  parameter int                    DATA_WIDTH  = 8,
  parameter logic [DATA_WIDTH-1:0] HEADER_BYTE = 8'hA5
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  frame_tick,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  input  logic                  m_ready,
  output logic                  busy,
  output logic [7:0]            frames_dropped
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_HEADER = 3'd1,
    S_READ   = 3'd2,
    S_LATCH  = 3'd3,
    S_SEND   = 3'd4
`ifdef FB_SCANOUT_CHECKSUM_EN
    ,
    S_CSUM   = 3'd5
`endif
  } state_t;

  state_t                  state_q,   state_d;
  logic [ADDR_WIDTH-1:0]   counter_q, counter_d;
  logic [ADDR_WIDTH-1:0]   rd_addr_q, rd_addr_d;
  logic                    valid_q,   valid_d;
  logic [DATA_WIDTH-1:0]   data_q,    data_d;
  logic                    last_q,    last_d;
  logic                    busy_q,    busy_d;
  logic [7:0]              dropped_q, dropped_d;
`ifdef FB_SCANOUT_CHECKSUM_EN
  logic [DATA_WIDTH-1:0]   sum_q,     sum_d;
`endif

  logic handshake;
  logic at_last_addr;

  assign handshake    = valid_q & m_ready;
  assign at_last_addr = (counter_q == LAST_ADDR);

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    // NOTE: every variable gets its hold value first so no path through the
    // case statement leaves one unassigned, which would infer a latch.
    state_d   = state_q;
    counter_d = counter_q;
    rd_addr_d = rd_addr_q;
    valid_d   = valid_q;
    data_d    = data_q;
    last_d    = last_q;
    busy_d    = busy_q;
    dropped_d = dropped_q;
`ifdef FB_SCANOUT_CHECKSUM_EN
    sum_d     = sum_q;
`endif

    // A tick that arrives while a dump is in flight is dropped and counted,
    // including one landing on the edge of the final handshake.
    if (frame_tick && (state_q != S_IDLE) && (dropped_q != 8'hFF)) begin
      dropped_d = dropped_q + 8'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (frame_tick) begin
          state_d   = S_HEADER;
          valid_d   = 1'b1;
          data_d    = HEADER_BYTE;
          last_d    = 1'b0;
          busy_d    = 1'b1;
          counter_d = '0;
`ifdef FB_SCANOUT_CHECKSUM_EN
          sum_d     = '0;
`endif
        end
      end

      S_HEADER: begin
        if (handshake) begin
          state_d   = S_READ;
          rd_addr_d = counter_q;
          valid_d   = 1'b0;
        end
      end

      // The RAM samples rd_addr on this edge; its data appears one cycle on.
      S_READ: begin
        state_d = S_LATCH;
      end

      S_LATCH: begin
        state_d = S_SEND;
        data_d  = rd_data;
        valid_d = 1'b1;
`ifdef FB_SCANOUT_CHECKSUM_EN
        last_d  = 1'b0;
`else
        last_d  = at_last_addr;
`endif
      end

      // Byte is held stable until the sink takes it.
      S_SEND: begin
        if (handshake) begin
          valid_d = 1'b0;
`ifdef FB_SCANOUT_CHECKSUM_EN
          sum_d   = sum_q + data_q;
`endif
          if (!at_last_addr) begin
            state_d   = S_READ;
            counter_d = counter_q + 1'b1;
            rd_addr_d = counter_q + 1'b1;
          end else begin
`ifdef FB_SCANOUT_CHECKSUM_EN
            state_d = S_CSUM;
            valid_d = 1'b1;
            data_d  = sum_q + data_q;
            last_d  = 1'b1;
`else
            state_d = S_IDLE;
            last_d  = 1'b0;
            busy_d  = 1'b0;
`endif
          end
        end
      end

`ifdef FB_SCANOUT_CHECKSUM_EN
      S_CSUM: begin
        if (handshake) begin
          state_d = S_IDLE;
          valid_d = 1'b0;
          last_d  = 1'b0;
          busy_d  = 1'b0;
        end
      end
`endif

      // Unreachable encodings fall back to a clean idle.
      default: begin
        state_d = S_IDLE;
        valid_d = 1'b0;
        last_d  = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset clears everything and aborts a frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      counter_q <= '0;
      rd_addr_q <= '0;
      valid_q   <= 1'b0;
      data_q    <= '0;
      last_q    <= 1'b0;
      busy_q    <= 1'b0;
      dropped_q <= 8'h00;
`ifdef FB_SCANOUT_CHECKSUM_EN
      sum_q     <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q   <= state_d;
      counter_q <= counter_d;
      rd_addr_q <= rd_addr_d;
      valid_q   <= valid_d;
      data_q    <= data_d;
      last_q    <= last_d;
      busy_q    <= busy_d;
      dropped_q <= dropped_d;
`ifdef FB_SCANOUT_CHECKSUM_EN
      sum_q     <= sum_d;
`endif
    end
  end

  assign rd_addr        = rd_addr_q;
  assign m_valid        = valid_q;
  assign m_data         = data_q;
  assign m_last         = last_q;
  assign busy           = busy_q;
  assign frames_dropped = dropped_q;

endmodule

// File: tb/tb_fb_scanout.sv
// tb_fb_scanout: directed bench for fb_scanout with a one-cycle-latency RAM
// model on the read port. Outputs are sampled and inputs driven on negedges.
module tb_fb_scanout;

  localparam int AW = 8;
  localparam int DW = 8;
`ifdef FB_SCANOUT_CHECKSUM_EN
  localparam int FRAME_BEATS = 258;
  localparam int LAST_CYCLE  = 769;
`else
  localparam int FRAME_BEATS = 257;
  localparam int LAST_CYCLE  = 768;
`endif

  logic          clk        = 1'b0;
  logic          reset_n    = 1'b1;
  logic          frame_tick = 1'b0;
  logic          m_ready    = 1'b0;
  logic [DW-1:0] rd_data;
  logic [AW-1:0] rd_addr;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          busy;
  logic [7:0]    frames_dropped;

  logic [DW-1:0] ram      [0:255];
  logic [DW-1:0] exp_data [0:259];
  logic          exp_last [0:259];
  int            exp_len;

  int checks = 0;
  int errors = 0;

  // Results of the most recent capture.
  int            beats, bad_data, bad_last, first_bad, unstable, cycles;
  bit            timed_out;
  logic [DW-1:0] last_data;

  always #5 clk = ~clk;

  // Framebuffer port B: synchronous read, data one cycle after the address.
  always @(posedge clk) rd_data <= ram[rd_addr];

  fb_scanout #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .HEADER_BYTE(8'hA5)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .frame_tick    (frame_tick),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data),
    .m_valid       (m_valid),
    .m_data        (m_data),
    .m_last        (m_last),
    .m_ready       (m_ready),
    .busy          (busy),
    .frames_dropped(frames_dropped)
  );

  task automatic fill_ram(input int mode);
    for (int a = 0; a < 256; a++) begin
      case (mode)
        0:       ram[a] = 8'(a) ^ 8'h3C;
        1:       ram[a] = 8'(a);
        default: ram[a] = 8'h01;
      endcase
    end
  endtask

  task automatic build_expected();
    logic [DW-1:0] sum;
    sum = 8'h00;
    exp_data[0] = 8'hA5;
    exp_last[0] = 1'b0;
    for (int a = 0; a < 256; a++) begin
      exp_data[a+1] = ram[a];
      exp_last[a+1] = 1'b0;
      sum = sum + ram[a];
    end
`ifdef FB_SCANOUT_CHECKSUM_EN
    exp_data[257] = sum;
    exp_last[257] = 1'b1;
    exp_len = 258;
`else
    exp_last[256] = 1'b1;
    exp_len = 257;
`endif
  endtask

  task automatic do_reset();
    frame_tick = 1'b0;
    m_ready    = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  // Pulse frame_tick for one cycle; returns on the negedge the header is due.
  task automatic start_frame();
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  // Runs the sink from the current negedge until the m_last beat, stop_after
  // beats, or the cycle limit. Optional drop ticks every 20 cycles from
  // tick_start, and an optional tick on the final handshake edge.
  task automatic capture(input int ready_pct, input int n_ticks, input int tick_start,
                         input bit tick_on_last, input int stop_after, input int limit);
    bit            done, prev_stall, prev_last;
    logic [DW-1:0] prev_data;
    beats = 0; bad_data = 0; bad_last = 0; first_bad = -1; unstable = 0;
    cycles = 0; timed_out = 1'b0; last_data = '0;
    done = 1'b0; prev_stall = 1'b0; prev_last = 1'b0; prev_data = '0;
    for (int cyc = 0; !done; cyc++) begin
      if (cyc > limit) begin
        timed_out = 1'b1;
        break;
      end
      if (cyc > 0) @(negedge clk);
      if (prev_stall && (m_valid !== 1'b1 || m_data !== prev_data || m_last !== prev_last))
        unstable++;
      m_ready = (ready_pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < ready_pct);
      frame_tick = (n_ticks > 0) && (cyc >= tick_start) && ((cyc - tick_start) % 20 == 0)
                   && ((cyc - tick_start) / 20 < n_ticks);
      if (m_valid === 1'b1 && m_ready) begin
        if (beats >= exp_len || m_data !== exp_data[beats]) begin
          bad_data++;
          if (first_bad < 0) first_bad = beats;
        end else if (m_last !== exp_last[beats]) begin
          bad_last++;
        end
        last_data = m_data;
        beats++;
        if (m_last === 1'b1 || beats == stop_after) begin
          done   = 1'b1;
          cycles = cyc;
          if (tick_on_last && m_last === 1'b1) frame_tick = 1'b1;
        end
      end
      prev_stall = (m_valid === 1'b1) && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
    end
  endtask

  task automatic test_reset();
    #1 reset_n = 1'b0;
    #1;
    checks++;
    if ({rd_addr, m_valid, m_data, m_last, busy, frames_dropped} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got addr=%h v=%b d=%h l=%b busy=%b drop=%h, expected all 0",
               rd_addr, m_valid, m_data, m_last, busy, frames_dropped);
    end
    frame_tick = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || m_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_held_tick: got busy=%b valid=%b, expected 0/0", busy, m_valid);
    end
    frame_tick = 1'b0;
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic_frame();
    fill_ram(0);
    build_expected();
    do_reset();
    start_frame();
    checks++;
    if (m_valid !== 1'b1 || m_data !== 8'hA5 || busy !== 1'b1 || m_last !== 1'b0) begin
      errors++;
      $display("FAIL basic_header_latency: got v=%b d=%h busy=%b l=%b, expected 1/a5/1/0",
               m_valid, m_data, busy, m_last);
    end
    capture(100, 0, 0, 1'b0, 0, 4000);
    checks++;
    if (timed_out || beats != FRAME_BEATS) begin
      errors++;
      $display("FAIL basic_len: got %0d beats (timeout=%0b), expected %0d", beats, timed_out, FRAME_BEATS);
    end
    checks++;
    if (bad_data != 0) begin
      errors++;
      $display("FAIL basic_data: got %0d bad bytes (first at beat %0d), expected 0", bad_data, first_bad);
    end
    checks++;
    if (bad_last != 0) begin
      errors++;
      $display("FAIL basic_last: got %0d misplaced m_last, expected 0", bad_last);
    end
    checks++;
    if (cycles != LAST_CYCLE) begin
      errors++;
      $display("FAIL basic_throughput: last beat at cycle %0d, expected %0d", cycles, LAST_CYCLE);
    end
    @(negedge clk);
    m_ready = 1'b0;
    checks++;
    if (busy !== 1'b0 || m_valid !== 1'b0 || m_last !== 1'b0 || frames_dropped !== 8'h00) begin
      errors++;
      $display("FAIL basic_end: got busy=%b v=%b l=%b drop=%h, expected 0/0/0/00",
               busy, m_valid, m_last, frames_dropped);
    end
  endtask

  task automatic test_backpressure();
    fill_ram(0);
    build_expected();
    do_reset();
    start_frame();
    capture(30, 0, 0, 1'b0, 0, 20000);
    checks++;
    if (timed_out || beats != FRAME_BEATS || bad_data != 0 || bad_last != 0) begin
      errors++;
      $display("FAIL bp_stream: got beats=%0d bad=%0d badlast=%0d timeout=%0b, expected %0d/0/0/0",
               beats, bad_data, bad_last, timed_out, FRAME_BEATS);
    end
    checks++;
    if (unstable != 0) begin
      errors++;
      $display("FAIL bp_stability: got %0d changes during stall, expected 0", unstable);
    end
    @(negedge clk);
    m_ready = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL bp_end_busy: got %b, expected 0", busy);
    end
  endtask

  task automatic test_drops();
    int extra;
    fill_ram(0);
    build_expected();
    // Three ticks in the middle of a dump.
    do_reset();
    start_frame();
    capture(100, 3, 50, 1'b0, 0, 4000);
    checks++;
    if (timed_out || beats != FRAME_BEATS || bad_data != 0) begin
      errors++;
      $display("FAIL drop_frame: got beats=%0d bad=%0d, expected %0d/0", beats, bad_data, FRAME_BEATS);
    end
    checks++;
    if (frames_dropped !== 8'd3) begin
      errors++;
      $display("FAIL drop_count3: got %0d, expected 3", frames_dropped);
    end
    extra = 0;
    repeat (30) begin
      @(negedge clk);
      if (m_valid === 1'b1 || busy === 1'b1) extra++;
    end
    m_ready = 1'b0;
    checks++;
    if (extra != 0) begin
      errors++;
      $display("FAIL drop_single_frame: got %0d busy cycles after frame, expected 0", extra);
    end
    // 300 ticks against a stalled header saturate the counter.
    do_reset();
    start_frame();
    frame_tick = 1'b1;
    repeat (300) @(negedge clk);
    frame_tick = 1'b0;
    @(negedge clk);
    checks++;
    if (frames_dropped !== 8'hFF) begin
      errors++;
      $display("FAIL drop_saturate: got %h, expected ff", frames_dropped);
    end
    checks++;
    if (m_valid !== 1'b1 || m_data !== 8'hA5) begin
      errors++;
      $display("FAIL drop_stall_hold: got v=%b d=%h, expected 1/a5", m_valid, m_data);
    end
    // Tick on the final handshake edge counts as dropped and starts nothing.
    do_reset();
    start_frame();
    capture(100, 0, 0, 1'b1, 0, 4000);
    @(negedge clk);
    frame_tick = 1'b0;
    m_ready    = 1'b0;
    checks++;
    if (frames_dropped !== 8'd1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL drop_last_edge: got drop=%0d busy=%b, expected 1/0", frames_dropped, busy);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || m_valid !== 1'b0) begin
      errors++;
      $display("FAIL drop_last_no_start: got busy=%b v=%b, expected 0/0", busy, m_valid);
    end
  endtask

  task automatic test_reset_mid_frame();
    fill_ram(0);
    build_expected();
    do_reset();
    start_frame();
    capture(100, 0, 0, 1'b0, 102, 4000);
    checks++;
    if (timed_out || beats != 102 || bad_data != 0) begin
      errors++;
      $display("FAIL midrst_prefix: got beats=%0d bad=%0d, expected 102/0", beats, bad_data);
    end
    @(posedge clk);
    #2;
    checks++;
    if (rd_addr !== 8'd101 || busy !== 1'b1) begin
      errors++;
      $display("FAIL midrst_before: got addr=%0d busy=%b, expected 101/1", rd_addr, busy);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({rd_addr, m_valid, m_data, m_last, busy, frames_dropped} !== '0) begin
      errors++;
      $display("FAIL midrst_async: got addr=%h v=%b d=%h l=%b busy=%b drop=%h, expected all 0",
               rd_addr, m_valid, m_data, m_last, busy, frames_dropped);
    end
    m_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    start_frame();
    capture(100, 0, 0, 1'b0, 0, 4000);
    checks++;
    if (timed_out || beats != FRAME_BEATS || bad_data != 0 || bad_last != 0) begin
      errors++;
      $display("FAIL midrst_refresh: got beats=%0d bad=%0d (first %0d) badlast=%0d, expected %0d/0/0",
               beats, bad_data, first_bad, bad_last, FRAME_BEATS);
    end
    @(negedge clk);
    m_ready = 1'b0;
  endtask

`ifdef FB_SCANOUT_CHECKSUM_EN
  task automatic test_checksum();
    fill_ram(1);
    build_expected();
    do_reset();
    start_frame();
    capture(100, 0, 0, 1'b0, 0, 4000);
    checks++;
    if (timed_out || beats != 258 || last_data !== 8'h80 || bad_last != 0 || bad_data != 0) begin
      errors++;
      $display("FAIL csum_ramp: got beats=%0d sum=%h badlast=%0d bad=%0d, expected 258/80/0/0",
               beats, last_data, bad_last, bad_data);
    end
    @(negedge clk);
    m_ready = 1'b0;
    fill_ram(2);
    build_expected();
    do_reset();
    start_frame();
    capture(100, 0, 0, 1'b0, 0, 4000);
    checks++;
    if (timed_out || beats != 258 || last_data !== 8'h00 || bad_last != 0) begin
      errors++;
      $display("FAIL csum_ones: got beats=%0d sum=%h badlast=%0d, expected 258/00/0",
               beats, last_data, bad_last);
    end
    @(negedge clk);
    m_ready = 1'b0;
  endtask
`endif

  initial begin
    fill_ram(0);
    test_reset();
    test_basic_frame();
    test_backpressure();
    test_drops();
    test_reset_mid_frame();
`ifdef FB_SCANOUT_CHECKSUM_EN
    test_checksum();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
